// File: rtl/ecc_ctrl_pkg.sv
// Shared widths and state/owner encodings for the ECC scrub controller.
package ecc_ctrl_pkg;

  localparam int CW_W   = 39;
  localparam int DATA_W = 32;
  localparam int CHK_W  = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    DEC  = 2'd2,
    WB   = 2'd3
  } state_e;

  typedef enum logic {
    HOST  = 1'b0,
    SCRUB = 1'b1
  } owner_e;

endpackage

// File: rtl/ecc_scrub_timer.sv
// Scrub interval timer, pending/override ageing, scrub address pointer and
// wrap pulse for the ECC scrub controller.
module ecc_scrub_timer
  import ecc_ctrl_pkg::*;
#(
  parameter int AW             = 10,
  parameter int DEPTH          = 1024,
  parameter int SCRUB_INTERVAL = 256
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          i_en,
  input  logic          i_take,
  input  logic          i_advance,
  output logic          o_pending,
  output logic          o_override,
  output logic [AW-1:0] o_ptr,
  output logic          o_done
);

  localparam int TW = $clog2(SCRUB_INTERVAL);
  localparam int GW = $clog2(SCRUB_INTERVAL + 1);
  localparam logic [TW-1:0] RELOAD  = TW'(SCRUB_INTERVAL - 1);
  localparam logic [GW-1:0] AGE_MAX = GW'(SCRUB_INTERVAL);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  logic [TW-1:0] r_timer;
  logic [GW-1:0] r_age;
  logic [AW-1:0] r_ptr;
  logic          r_pend;
  logic          r_done;

  // NOTE: state updates use non-blocking assignments only, and the async
  // reset puts every register into a known value.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_timer <= RELOAD;
      r_age   <= '0;
      r_ptr   <= '0;
      r_pend  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_en) begin
        r_timer <= (r_timer == '0) ? RELOAD : r_timer - 1'b1;
      end
      // A take clears pending; an expiry that lands while pending is dropped.
      if (i_take) begin
        r_pend <= 1'b0;
      end else if (i_en && (r_timer == '0)) begin
        r_pend <= 1'b1;
      end
      if (!r_pend || i_take) begin
        r_age <= '0;
      end else if (r_age != AGE_MAX) begin
        r_age <= r_age + 1'b1;
      end
      if (i_advance) begin
        if (r_ptr == LAST) begin
          r_ptr  <= '0;
          r_done <= 1'b1;
        end else begin
          r_ptr <= r_ptr + 1'b1;
        end
      end
    end
  end

  assign o_pending  = r_pend;
  assign o_override = r_pend && (r_age == AGE_MAX);
  assign o_ptr      = r_ptr;
  assign o_done     = r_done;

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Host/scrub sequencer around one shared (39,32) SEC-DED decode path.
// Define ECC_ERR_INJECT_EN to add the INJ_MASK/INJ_ARM fault-injection ports.
module ecc_scrub_ctrl
  import ecc_ctrl_pkg::*;
#(
  parameter int AW             = 10,
  parameter int DEPTH          = 1024,
  parameter int SCRUB_INTERVAL = 256,
  parameter int CNT_W          = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              HREQ,
  input  logic [AW-1:0]     HADDR,
  output logic              HACK,
  output logic              HVALID,
  output logic [DATA_W-1:0] HDATA,
  output logic              HSGL,
  output logic              HDBL,
  output logic              MEM_RE,
  output logic              MEM_WE,
  output logic [AW-1:0]     MEM_ADDR,
  output logic [CW_W-1:0]   MEM_WDATA,
  input  logic [CW_W-1:0]   MEM_RDATA,
  output logic [CW_W-1:0]   DEC_IN,
  input  logic [CW_W-1:0]   DEC_OUT,
  input  logic              DEC_SGL,
  input  logic              DEC_DBL,
`ifdef ECC_ERR_INJECT_EN
  input  logic [CW_W-1:0]   INJ_MASK,
  input  logic              INJ_ARM,
`endif
  input  logic              SCRUB_EN,
  output logic              SCRUB_DONE,
  output logic [CNT_W-1:0]  SGL_CNT,
  output logic [CNT_W-1:0]  DBL_CNT,
  output logic [AW-1:0]     DBL_ADDR,
  output logic              DBL_IRQ,
  input  logic              DBL_CLR
);

  state_e            r_state;
  owner_e            r_owner;
  logic [AW-1:0]     r_addr;
  logic [AW-1:0]     r_dbl_addr;
  logic [CW_W-1:0]   r_dec_in;
  logic [CW_W-1:0]   r_wdata;
  logic [DATA_W-1:0] r_hdata;
  logic              r_hvalid, r_hsgl, r_hdbl, r_we, r_irq;
  logic [CNT_W-1:0]  r_sgl_cnt, r_dbl_cnt;

  logic              w_pending, w_override, w_scrub_done;
  logic [AW-1:0]     w_ptr;
  logic              w_idle, w_scrub_go, w_host_go, w_sgl, w_advance;
  logic [CW_W-1:0]   w_inj_mask;

  // NOTE: the grant is decoded combinationally in IDLE so HACK, MEM_RE and
  // MEM_ADDR appear in the acceptance cycle; all other outputs are registered.
  assign w_idle     = (r_state == IDLE);
  assign w_scrub_go = w_idle && w_pending && (!HREQ || w_override);
  assign w_host_go  = w_idle && HREQ && !w_scrub_go;
  assign w_sgl      = DEC_SGL && !DEC_DBL;
  assign w_advance  = (r_owner == SCRUB) &&
                      (((r_state == DEC) && !w_sgl) || (r_state == WB));

  ecc_scrub_timer #(
    .AW             (AW),
    .DEPTH          (DEPTH),
    .SCRUB_INTERVAL (SCRUB_INTERVAL)
  ) u_timer (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .i_en       (SCRUB_EN),
    .i_take     (w_scrub_go),
    .i_advance  (w_advance),
    .o_pending  (w_pending),
    .o_override (w_override),
    .o_ptr      (w_ptr),
    .o_done     (w_scrub_done)
  );

`ifdef ECC_ERR_INJECT_EN
  logic            r_inj_armed;
  logic [CW_W-1:0] r_inj_mask;

  // Arming during RD targets the following access, so arm wins over disarm.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_inj_armed <= 1'b0;
      r_inj_mask  <= '0;
    end else if (INJ_ARM) begin
      r_inj_armed <= 1'b1;
      r_inj_mask  <= INJ_MASK;
    end else if (r_state == RD) begin
      r_inj_armed <= 1'b0;
    end
  end

  assign w_inj_mask = r_inj_armed ? r_inj_mask : '0;
`else
  assign w_inj_mask = '0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      r_owner    <= HOST;
      r_addr     <= '0;
      r_dbl_addr <= '0;
      r_dec_in   <= '0;
      r_wdata    <= '0;
      r_hdata    <= '0;
      r_hvalid   <= 1'b0;
      r_hsgl     <= 1'b0;
      r_hdbl     <= 1'b0;
      r_we       <= 1'b0;
      r_irq      <= 1'b0;
      r_sgl_cnt  <= '0;
      r_dbl_cnt  <= '0;
    end else begin
      r_hvalid <= 1'b0;
      r_we     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_scrub_go) begin
            r_addr  <= w_ptr;
            r_owner <= SCRUB;
            r_state <= RD;
          end else if (w_host_go) begin
            r_addr  <= HADDR;
            r_owner <= HOST;
            r_state <= RD;
          end
        end
        RD: begin
          r_dec_in <= MEM_RDATA ^ w_inj_mask;
          r_state  <= DEC;
        end
        DEC: begin
          if (r_owner == HOST) begin
            r_hvalid <= 1'b1;
            r_hdata  <= DEC_OUT[DATA_W-1:0];
            r_hsgl   <= w_sgl;
            r_hdbl   <= DEC_DBL;
          end
          if (DEC_DBL) begin
            if (r_dbl_cnt != '1) r_dbl_cnt <= r_dbl_cnt + 1'b1;
            r_dbl_addr <= r_addr;
            r_state    <= IDLE;
          end else if (w_sgl) begin
            if (r_sgl_cnt != '1) r_sgl_cnt <= r_sgl_cnt + 1'b1;
            r_we    <= 1'b1;
            r_wdata <= DEC_OUT;
            r_state <= WB;
          end else begin
            r_state <= IDLE;
          end
        end
        WB:      r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if ((r_state == DEC) && DEC_DBL) begin
        r_irq <= 1'b1;
      end else if (DBL_CLR) begin
        r_irq <= 1'b0;
      end
    end
  end

  assign HACK       = w_host_go;
  assign MEM_RE     = w_scrub_go || w_host_go;
  assign MEM_ADDR   = w_scrub_go ? w_ptr :
                      w_host_go  ? HADDR :
                      (r_state == WB) ? r_addr : '0;
  assign MEM_WE     = r_we;
  assign MEM_WDATA  = r_wdata;
  assign DEC_IN     = r_dec_in;
  assign HVALID     = r_hvalid;
  assign HDATA      = r_hdata;
  assign HSGL       = r_hsgl;
  assign HDBL       = r_hdbl;
  assign SCRUB_DONE = w_scrub_done;
  assign SGL_CNT    = r_sgl_cnt;
  assign DBL_CNT    = r_dbl_cnt;
  assign DBL_ADDR   = r_dbl_addr;
  assign DBL_IRQ    = r_irq;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed bench for ecc_scrub_ctrl with a behavioural ECC memory and an
// independent Hsiao (39,32) decoder model.
module tb_ecc_scrub_ctrl;

  logic        clk, rst_n;
  logic        hreq, hack, hvalid, hsgl, hdbl;
  logic [9:0]  haddr, mem_addr, dbl_addr;
  logic [31:0] hdata;
  logic        mem_re, mem_we;
  logic [38:0] mem_wdata, mem_rdata, dec_in, dec_out;
  logic        dec_sgl, dec_dbl;
  logic        scrub_en, scrub_done, dbl_irq, dbl_clr;
  logic [15:0] sgl_cnt, dbl_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  ecc_scrub_ctrl #(
    .AW             (10),
    .DEPTH          (8),
    .SCRUB_INTERVAL (4),
    .CNT_W          (16)
  ) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .HREQ       (hreq),
    .HADDR      (haddr),
    .HACK       (hack),
    .HVALID     (hvalid),
    .HDATA      (hdata),
    .HSGL       (hsgl),
    .HDBL       (hdbl),
    .MEM_RE     (mem_re),
    .MEM_WE     (mem_we),
    .MEM_ADDR   (mem_addr),
    .MEM_WDATA  (mem_wdata),
    .MEM_RDATA  (mem_rdata),
    .DEC_IN     (dec_in),
    .DEC_OUT    (dec_out),
    .DEC_SGL    (dec_sgl),
    .DEC_DBL    (dec_dbl),
`ifdef ECC_ERR_INJECT_EN
    .INJ_MASK   (39'd0),
    .INJ_ARM    (1'b0),
`endif
    .SCRUB_EN   (scrub_en),
    .SCRUB_DONE (scrub_done),
    .SGL_CNT    (sgl_cnt),
    .DBL_CNT    (dbl_cnt),
    .DBL_ADDR   (dbl_addr),
    .DBL_IRQ    (dbl_irq),
    .DBL_CLR    (dbl_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hsiao columns: data bit i uses the i-th weight-3 7-bit value in ascending order.
  function automatic logic [6:0] col_of(input int i);
    logic [6:0] res;
    int k;
    logic [6:0] v7;
    res = '0;
    k = 0;
    for (int v = 0; v < 128; v++) begin
      v7 = v[6:0];
      if ($countones(v7) == 3) begin
        if (k == i) res = v7;
        k++;
      end
    end
    return res;
  endfunction

  function automatic logic [6:0] chk(input logic [31:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) if (d[i]) c ^= col_of(i);
    return c;
  endfunction

  function automatic logic [38:0] enc(input logic [31:0] d);
    return {chk(d), d};
  endfunction

  function automatic logic [40:0] decode(input logic [38:0] cw);
    logic [6:0]  s;
    logic [38:0] fixed;
    logic        sgl, dbl, found;
    s = chk(cw[31:0]) ^ cw[38:32];
    fixed = cw;
    sgl = 1'b0;
    dbl = 1'b0;
    found = 1'b0;
    if (s != '0) begin
      if ($countones(s) % 2 == 1) begin
        for (int i = 0; i < 32; i++) begin
          if (col_of(i) == s) begin
            fixed[i] = ~fixed[i];
            found = 1'b1;
          end
        end
        if (!found && ($countones(s) == 1)) begin
          for (int j = 0; j < 7; j++) if (s[j]) fixed[32+j] = ~fixed[32+j];
          found = 1'b1;
        end
        sgl = found;
        dbl = !found;
      end else begin
        dbl = 1'b1;
      end
    end
    return {sgl, dbl, fixed};
  endfunction

  always_comb {dec_sgl, dec_dbl, dec_out} = decode(dec_in);

  // Single-port memory model with a backdoor write port for preloading.
  logic [38:0] mem [0:1023];
  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [38:0] bd_data;

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (bd_we) mem[bd_addr] <= bd_data;
  end

  // Scrub read / wrap monitor.
  logic       mon_on = 1'b0;
  logic [9:0] scrub_q[$];
  int         done_cnt = 0;
  int         done_pos = -1;

  always @(negedge clk) begin
    if (mon_on) begin
      if (mem_re && !hack) scrub_q.push_back(mem_addr);
      if (scrub_done) begin
        done_cnt++;
        done_pos = scrub_q.size();
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [38:0] d);
    @(posedge clk); #1;
    bd_we = 1'b1;
    bd_addr = a;
    bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic wait_hack(input string tag);
    int n;
    n = 0;
    while (hack !== 1'b1 && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    check({tag, "_hack"}, hack, 1'b1);
  endtask

  // One host read: HACK in t, HVALID in t+3; DBL_CLR optionally driven in t+2.
  task automatic host_read(input string tag, input logic [9:0] a, input logic [31:0] ed,
                           input logic es, input logic edb, input logic ewe,
                           input logic [38:0] ewd, input logic clr_dec);
    @(posedge clk); #1;
    hreq = 1'b1;
    haddr = a;
    #1;
    wait_hack(tag);
    check({tag, "_addr_t"}, mem_addr, a);
    @(posedge clk); #1;
    hreq = 1'b0;
    #1;
    check({tag, "_hvalid_t1"}, hvalid, 1'b0);
    @(posedge clk); #1;
    dbl_clr = clr_dec;
    #1;
    check({tag, "_hvalid_t2"}, hvalid, 1'b0);
    @(posedge clk); #1;
    dbl_clr = 1'b0;
    #1;
    check({tag, "_hvalid_t3"}, hvalid, 1'b1);
    check({tag, "_hsgl"}, hsgl, es);
    check({tag, "_hdbl"}, hdbl, edb);
    if (!edb) check({tag, "_hdata"}, hdata, ed);
    check({tag, "_we_t3"}, mem_we, ewe);
    if (ewe) begin
      check({tag, "_wb_addr"}, mem_addr, a);
      check({tag, "_wb_data"}, mem_wdata, ewd);
    end
    @(posedge clk); #2;
    check({tag, "_hvalid_t4"}, hvalid, 1'b0);
    check({tag, "_we_t4"}, mem_we, 1'b0);
  endtask

  initial begin
    logic [38:0] sgl_word, dbl_word, dbl_word2;
    int n, first, hacks, seen_hv, seen_we;
    logic hack12;
    logic [9:0] ovr_addr;

    rst_n = 1'b0;
    hreq = 1'b0;
    haddr = '0;
    scrub_en = 1'b0;
    dbl_clr = 1'b0;
    bd_we = 1'b0;
    bd_addr = '0;
    bd_data = '0;

    sgl_word  = enc(32'h1234_5678) ^ (39'd1 << 7);
    dbl_word  = enc(32'hCAFE_F00D) ^ (39'd1 << 3) ^ (39'd1 << 20);
    dbl_word2 = enc(32'h0BAD_F00D) ^ 39'd3;
    for (int i = 0; i < 8; i++) poke(10'(i), enc(32'h1000_0000 + i));
    poke(10'd5, enc(32'hDEAD_BEEF));
    poke(10'd9, sgl_word);
    poke(10'h12, dbl_word);
    poke(10'h13, dbl_word2);

    #2;
    check("rst_hack", hack, 1'b0);
    check("rst_mem_re", mem_re, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_hvalid", hvalid, 1'b0);
    check("rst_dec_in", dec_in, 39'd0);
    check("rst_sgl_cnt", sgl_cnt, 16'd0);
    check("rst_dbl_irq", dbl_irq, 1'b0);
    check("rst_scrub_done", scrub_done, 1'b0);

    @(posedge clk); #1;
    rst_n = 1'b1;

    host_read("clean5", 10'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    host_read("sgl9", 10'd9, 32'h1234_5678, 1'b1, 1'b0, 1'b1, enc(32'h1234_5678), 1'b0);
    check("sgl_cnt_1", sgl_cnt, 16'd1);
    host_read("reread9", 10'd9, 32'h1234_5678, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("sgl_cnt_still_1", sgl_cnt, 16'd1);

    host_read("dbl12", 10'h12, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    check("dbl_cnt_1", dbl_cnt, 16'd1);
    check("dbl_addr_12", dbl_addr, 10'h12);
    check("dbl_irq_set", dbl_irq, 1'b1);
    @(posedge clk); #1;
    dbl_clr = 1'b1;
    @(posedge clk); #1;
    dbl_clr = 1'b0;
    #1;
    check("dbl_irq_cleared", dbl_irq, 1'b0);
    host_read("dbl13", 10'h13, '0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    check("dbl_irq_set_wins", dbl_irq, 1'b1);
    check("dbl_cnt_2", dbl_cnt, 16'd2);
    check("dbl_addr_13", dbl_addr, 10'h13);

    // Background sweep over DEPTH=8 with no host traffic.
    mon_on = 1'b1;
    scrub_en = 1'b1;
    n = 0;
    while (scrub_q.size() < 9 && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
    scrub_en = 1'b0;
    mon_on = 1'b0;
    check("sweep_timeout", (n < 80), 1'b1);
    for (int i = 0; i < 9; i++) check($sformatf("scrub_addr_%0d", i), scrub_q[i], 10'(i % 8));
    check("scrub_done_cnt", done_cnt, 1);
    check("scrub_done_pos", done_pos, 8);
    check("sweep_sgl_cnt", sgl_cnt, 16'd1);

    // Override under continuous host traffic, from a fresh reset.
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    hreq = 1'b1;
    haddr = 10'd5;
    scrub_en = 1'b1;
    first = -1;
    hacks = 0;
    hack12 = 1'b0;
    ovr_addr = '1;
    for (int c = 0; c < 14; c++) begin
      #1;
      if (first < 0) begin
        if (mem_re && !hack) begin
          first = c;
          ovr_addr = mem_addr;
        end else if (hack) begin
          hacks++;
        end
      end
      if (c == 12) hack12 = hack;
      @(posedge clk); #1;
    end
    hreq = 1'b0;
    scrub_en = 1'b0;
    check("ovr_cycle", first, 9);
    check("ovr_addr", ovr_addr, 10'd0);
    check("ovr_host_grants", hacks, 3);
    check("ovr_host_resumes", hack12, 1'b1);

    // Reset during write-back.
    repeat (12) @(posedge clk);
    poke(10'd9, sgl_word);
    @(posedge clk); #1;
    hreq = 1'b1;
    haddr = 10'd9;
    #1;
    wait_hack("rst_wb");
    @(posedge clk); #1;
    hreq = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    check("rst_wb_we_before", mem_we, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_wb_we", mem_we, 1'b0);
    check("rst_wb_hvalid", hvalid, 1'b0);
    check("rst_wb_addr", mem_addr, 10'd0);
    check("rst_wb_wdata", mem_wdata, 39'd0);
    check("rst_wb_sgl_cnt", sgl_cnt, 16'd0);
    check("rst_wb_hdata", hdata, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wb_mem_untouched", mem[9], sgl_word);

    // Reset during RD: the access is dropped without HVALID or write-back.
    hreq = 1'b1;
    haddr = 10'd9;
    #1;
    wait_hack("rst_rd");
    @(posedge clk); #1;
    hreq = 1'b0;
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_hv = 0;
    seen_we = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #2;
      if (hvalid) seen_hv++;
      if (mem_we) seen_we++;
    end
    check("rst_rd_no_hvalid", seen_hv, 0);
    check("rst_rd_no_wb", seen_we, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, limit 100000 expected finish earlier");
    $fatal(1, "watchdog");
  end

endmodule
